// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode/issue; buffers {inst, pc} pairs.
// Optional IQ_BYPASS_EN: an empty queue forwards a fetch push straight to issue in one edge.
module inst_queue #(
    parameter int unsigned IQ_DEPTH_LOG2 = 4,
    parameter int unsigned INST_W        = 32,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              IF_inst_valid,
    input  logic [INST_W-1:0] IF_inst,
    input  logic [ADDR_W-1:0] IF_pc,
    output logic              IQ_queue_is_full,
    input  logic              Issue_stall,
    output logic              Issue_inst_valid,
    output logic [INST_W-1:0] Issue_inst,
    output logic [ADDR_W-1:0] Issue_pc,
    input  logic              ROB_jump_judge
);

    localparam int unsigned DEPTH = 1 << IQ_DEPTH_LOG2;
    localparam int unsigned CNT_W = IQ_DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = IQ_DEPTH_LOG2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               bypass_c;
    logic               do_push_c;
    logic               do_pop_c;
    logic               wr_en_c;

    // One slot of headroom absorbs the push already in flight when fetch sees full.
    assign IQ_queue_is_full = (count >= CNT_W'(DEPTH - 1));

`ifdef IQ_BYPASS_EN
    assign bypass_c = IF_inst_valid && !Issue_stall && (count == '0);
`else
    assign bypass_c = 1'b0;
`endif

    assign do_push_c = IF_inst_valid && (count < CNT_W'(DEPTH)) && !bypass_c;
    assign do_pop_c  = !Issue_stall && (count != '0);
    assign wr_en_c   = !rst && rdy && !ROB_jump_judge && do_push_c;

    // Storage has no reset; contents are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[tail] <= '{inst: IF_inst, pc: IF_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            Issue_inst_valid <= 1'b0;
            Issue_inst       <= '0;
            Issue_pc         <= '0;
        end else if (rdy) begin
            if (ROB_jump_judge) begin
                head             <= '0;
                tail             <= '0;
                count            <= '0;
                Issue_inst_valid <= 1'b0;
            end else begin
                if (do_push_c) begin
                    tail <= tail + PTR_W'(1);
                end
                // Pop reads the old head entry, never the one being written this edge.
                if (do_pop_c) begin
                    Issue_inst_valid <= 1'b1;
                    Issue_inst       <= mem[head].inst;
                    Issue_pc         <= mem[head].pc;
                    head             <= head + PTR_W'(1);
                end else if (bypass_c) begin
                    Issue_inst_valid <= 1'b1;
                    Issue_inst       <= IF_inst;
                    Issue_pc         <= IF_pc;
                end else begin
                    Issue_inst_valid <= 1'b0;
                end
                count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
            end
        end
    end

    // A push into a completely full queue means fetch ignored the full flag.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rdy && !ROB_jump_judge && IF_inst_valid && !bypass_c && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue; expected values are hand-derived per scenario.
// Build with +define+IQ_BYPASS_EN to check the bypass variant.
module tb_inst_queue;

`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IF_inst_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic        IQ_queue_is_full;
    logic        Issue_stall;
    logic        Issue_inst_valid;
    logic [31:0] Issue_inst;
    logic [31:0] Issue_pc;
    logic        ROB_jump_judge;

    int errors = 0;
    int checks = 0;

    inst_queue dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .IF_inst_valid    (IF_inst_valid),
        .IF_inst          (IF_inst),
        .IF_pc            (IF_pc),
        .IQ_queue_is_full (IQ_queue_is_full),
        .Issue_stall      (Issue_stall),
        .Issue_inst_valid (Issue_inst_valid),
        .Issue_inst       (Issue_inst),
        .Issue_pc         (Issue_pc),
        .ROB_jump_judge   (ROB_jump_judge)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; outputs are sampled and inputs driven 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; IF_inst_valid = 1'b0; IF_inst = '0; IF_pc = '0;
        Issue_stall = 1'b0; ROB_jump_judge = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (IQ_queue_is_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", IQ_queue_is_full); end
        checks++;
        if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", Issue_inst_valid); end
        checks++;
        if (Issue_inst !== 32'h0 || Issue_pc !== 32'h0) begin
            errors++; $display("FAIL reset_data got inst=%h pc=%h exp 0/0", Issue_inst, Issue_pc);
        end
        // Empty queue: releasing issue for a cycle must yield no pulse.
        step();
        checks++;
        if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_empty got=%b exp=0", Issue_inst_valid); end
    endtask

    task automatic test_fill();
        Issue_stall = 1'b1;
        for (int k = 0; k < 16; k++) begin
            IF_inst_valid = 1'b1;
            IF_inst = 32'hA000_0000 | 32'(k);
            IF_pc   = 32'(4 * k);
            step();
            checks++;
            if (IQ_queue_is_full !== (k + 1 >= 15)) begin
                errors++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, IQ_queue_is_full, (k + 1 >= 15));
            end
            checks++;
            if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL fill_valid k=%0d got=%b exp=0", k, Issue_inst_valid); end
        end
        IF_inst_valid = 1'b0;
    endtask

    task automatic test_drain_order();
        Issue_stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (Issue_inst_valid !== 1'b1 || Issue_pc !== 32'(4 * i) || Issue_inst !== (32'hA000_0000 | 32'(i))) begin
                errors++;
                $display("FAIL drain i=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         i, Issue_inst_valid, Issue_pc, Issue_inst, 32'(4 * i), 32'hA000_0000 | 32'(i));
            end
            checks++;
            if (IQ_queue_is_full !== (i == 0)) begin
                errors++; $display("FAIL drain_full i=%0d got=%b exp=%b", i, IQ_queue_is_full, (i == 0));
            end
        end
        step();
        checks++;
        if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL drain_end got=%b exp=0", Issue_inst_valid); end
    endtask

    task automatic test_wrap_concurrent();
        int got = 0;
        Issue_stall = 1'b0;
        for (int cyc = 0; cyc < 40 + LAT; cyc++) begin
            IF_inst_valid = (cyc < 40);
            IF_inst = 32'hB000_0000 | 32'(cyc);
            IF_pc   = 32'h1000 + 32'(4 * cyc);
            step();
            checks++;
            if (Issue_inst_valid !== (cyc >= LAT - 1 && cyc < 40 + LAT - 1)) begin
                errors++; $display("FAIL wrap_valid cyc=%0d got=%b", cyc, Issue_inst_valid);
            end
            if (Issue_inst_valid === 1'b1) begin
                checks++;
                if (Issue_pc !== 32'h1000 + 32'(4 * got) || Issue_inst !== (32'hB000_0000 | 32'(got))) begin
                    errors++; $display("FAIL wrap_order n=%0d got pc=%h exp pc=%h", got, Issue_pc, 32'h1000 + 32'(4 * got));
                end
                got++;
            end
            checks++;
            if (IQ_queue_is_full !== 1'b0) begin errors++; $display("FAIL wrap_full cyc=%0d got=%b exp=0", cyc, IQ_queue_is_full); end
        end
        IF_inst_valid = 1'b0;
        checks++;
        if (got != 40) begin errors++; $display("FAIL wrap_count got=%0d exp=40", got); end
    endtask

    task automatic test_flush();
        int seen = 0;
        bit found = 1'b0;
        Issue_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            IF_inst_valid = 1'b1;
            IF_pc = 32'h2000 + 32'(4 * k);
            IF_inst = 32'hC000_0000 | 32'(k);
            step();
        end
        IF_pc = 32'h2FF0; IF_inst = 32'hCFFF_FFFF;
        ROB_jump_judge = 1'b1; Issue_stall = 1'b0;
        step();
        ROB_jump_judge = 1'b0; IF_inst_valid = 1'b0;
        checks++;
        if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", Issue_inst_valid); end
        checks++;
        if (IQ_queue_is_full !== 1'b0) begin errors++; $display("FAIL flush_full got=%b exp=0", IQ_queue_is_full); end
        step();
        checks++;
        if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=%b exp=0", Issue_inst_valid); end
        IF_inst_valid = 1'b1; IF_pc = 32'h100; IF_inst = 32'hD000_0100;
        step();
        IF_inst_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (Issue_inst_valid === 1'b1) begin
                if (!found) begin
                    checks++;
                    if (Issue_pc !== 32'h100) begin errors++; $display("FAIL flush_first got pc=%h exp=00000100", Issue_pc); end
                    found = 1'b1;
                end
                seen++;
            end
            step();
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL flush_pulses got=%0d exp=1", seen); end
    endtask

    task automatic test_bypass();
        Issue_stall = 1'b0;
        IF_inst_valid = 1'b1; IF_pc = 32'h200; IF_inst = 32'hE000_0200;
        step();
        IF_inst_valid = 1'b0;
        checks++;
        if (Issue_inst_valid !== BYP || (BYP && Issue_pc !== 32'h200)) begin
            errors++; $display("FAIL bypass_edge_n got v=%b pc=%h exp v=%b", Issue_inst_valid, Issue_pc, BYP);
        end
        step();
        checks++;
        if (Issue_inst_valid !== !BYP || (!BYP && Issue_pc !== 32'h200)) begin
            errors++; $display("FAIL bypass_edge_n1 got v=%b pc=%h exp v=%b", Issue_inst_valid, Issue_pc, !BYP);
        end
        step();
        checks++;
        if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL bypass_after got=%b exp=0", Issue_inst_valid); end
    endtask

    task automatic test_rdy_hold();
        int seen = 0;
        Issue_stall = 1'b0;
        rdy = 1'b0;
        IF_inst_valid = 1'b1; IF_pc = 32'h300; IF_inst = 32'hF000_0300;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (Issue_inst_valid !== 1'b0) begin errors++; $display("FAIL rdy_hold c=%0d got=%b exp=0", c, Issue_inst_valid); end
        end
        rdy = 1'b1;
        step();
        IF_inst_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (Issue_inst_valid === 1'b1) begin
                seen++;
                checks++;
                if (Issue_pc !== 32'h300) begin errors++; $display("FAIL rdy_pc got=%h exp=00000300", Issue_pc); end
            end
            step();
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL rdy_pulses got=%0d exp=1", seen); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_order();
        test_wrap_concurrent();
        test_flush();
        test_bypass();
        test_rdy_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
